// File: rtl/seq_detect_prog.sv
// seq_detect_prog: run-time programmable serial pattern detector.
// Matches a right-aligned pattern of 1..MAX_LEN bits (pat[len-1] arrives first)
// on a qualified bit stream. It supports overlapping and restart-after-match
// detection, keeps a saturating match counter and flags rejected configurations.
// Optional macro SEQ_DETECT_TIMEOUT_EN adds an idle-gap timeout. The timeout
// drops a stale partial match and pulses the timeout port.
module seq_detect_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1011),
   parameter int                 DEFAULT_LEN = 4,
   parameter int                 TIMEOUT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       inp_valid,
   input  logic                       inp_bit,
   input  logic                       overlap_en,
   input  logic                       cfg_load,
   input  logic [MAX_LEN-1:0]         cfg_pattern,
   input  logic [$clog2(MAX_LEN):0]   cfg_len,
   input  logic                       cnt_clr,
   output logic                       seq_seen,
   output logic                       cfg_err,
   output logic [CNT_W-1:0]           match_count
`ifdef SEQ_DETECT_TIMEOUT_EN
   ,
   output logic                       timeout
`endif
);

   localparam int                 LEN_W     = $clog2(MAX_LEN) + 1;
   localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   DEF_LEN_L = LEN_W'(DEFAULT_LEN);
   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   // Elaboration-time parameter sanity checks
   if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
      $error("seq_detect_prog: MAX_LEN must be 2..32");
   end
   if (DEFAULT_LEN < 1 || DEFAULT_LEN > MAX_LEN) begin : g_bad_def_len
      $error("seq_detect_prog: DEFAULT_LEN must be 1..MAX_LEN");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("seq_detect_prog: TIMEOUT_CYC must be at least 1");
   end

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               seen_q, seen_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] hist_shift_s;
   logic [LEN_W-1:0]   fill_inc_s;
   logic [MAX_LEN-1:0] mask_s;
   logic               match_s;
   logic               cfg_ok_s;
   logic               hist_unused_s;

   // The oldest history bit is shifted out and never compared
   assign hist_unused_s = hist_q[MAX_LEN-1];

`ifdef SEQ_DETECT_TIMEOUT_EN
   localparam int              IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] TO_L     = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              to_q, to_d;
`endif

   // Next-state logic: config load, bit acceptance, match and counter update
   always_comb begin
      hist_shift_s = {hist_q[MAX_LEN-2:0], inp_bit};
      fill_inc_s   = (fill_q >= len_q) ? len_q : (fill_q + LEN_ONE);
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_s[i] = (LEN_W'(i) < len_q);
      end
      match_s  = inp_valid && !cfg_load && (fill_inc_s == len_q) &&
                 (((hist_shift_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
      cfg_ok_s = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_LEN_L);

      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      len_d  = len_q;
      seen_d = 1'b0;
      err_d  = 1'b0;
      cnt_d  = cnt_q;

      // Configuration has priority; any bit on a load edge is dropped
      if (cfg_load) begin
         if (cfg_ok_s) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
         end else begin
            err_d  = 1'b1;
         end
      end else if (inp_valid) begin
         hist_d = hist_shift_s;
         fill_d = fill_inc_s;
         if (match_s) begin
            seen_d = 1'b1;
            if (!overlap_en) begin
               hist_d = {MAX_LEN{1'b0}};
               fill_d = {LEN_W{1'b0}};
            end else begin
               fill_d = fill_inc_s;
            end
         end else begin
            seen_d = 1'b0;
         end
      end else begin
         seen_d = 1'b0;
      end

      // Clear wins over a same-edge match; count saturates at all-ones
      if (cnt_clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (match_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end

`ifdef SEQ_DETECT_TIMEOUT_EN
      idle_d = idle_q;
      to_d   = 1'b0;
      if (cfg_load || inp_valid) begin
         idle_d = {IDLE_W{1'b0}};
      end else if (fill_q != {LEN_W{1'b0}}) begin
         if ((idle_q + IDLE_ONE) == TO_L) begin
            idle_d = {IDLE_W{1'b0}};
            to_d   = 1'b1;
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
         end else begin
            idle_d = idle_q + IDLE_ONE;
         end
      end else begin
         idle_d = {IDLE_W{1'b0}};
      end
`endif
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= {MAX_LEN{1'b0}};
         fill_q <= {LEN_W{1'b0}};
         pat_q  <= DEFAULT_PAT;
         len_q  <= DEF_LEN_L;
         seen_q <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         seen_q <= seen_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef SEQ_DETECT_TIMEOUT_EN
   // Idle-gap counter and timeout pulse register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q <= {IDLE_W{1'b0}};
         to_q   <= 1'b0;
      end else begin
         idle_q <= idle_d;
         to_q   <= to_d;
      end
   end

   assign timeout = to_q;
`endif

   assign seq_seen    = seen_q;
   assign cfg_err     = err_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: table of stimulus records with expected pulses,
// a scoreboard queue of expectations popped one edge later, plus hand-written
// saturation and idle-timeout sequences.
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       inp_valid;
   logic       inp_bit;
   logic       overlap_en;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cnt_clr;
   logic       seq_seen;
   logic       cfg_err;
   logic [7:0] match_count;
`ifdef SEQ_DETECT_TIMEOUT_EN
   logic       timeout;
`endif

   seq_detect_prog dut (
      .clk         (clk),
      .reset       (reset),
      .inp_valid   (inp_valid),
      .inp_bit     (inp_bit),
      .overlap_en  (overlap_en),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cnt_clr     (cnt_clr),
      .seq_seen    (seq_seen),
      .cfg_err     (cfg_err),
      .match_count (match_count)
`ifdef SEQ_DETECT_TIMEOUT_EN
      ,
      .timeout     (timeout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic       bitv;
      logic       load;
      logic [7:0] pat;
      logic [3:0] len;
      logic       clr;
      logic       ovl;
      logic       exp_seen;
      logic       exp_err;
      logic       exp_to;
   } vec_t;

   typedef struct packed {
      logic       seen;
      logic       err;
      logic       to;
      logic [7:0] cnt;
   } exp_t;

   vec_t tbl[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] model_cnt;
   int   step_no = 0;

   task automatic check1(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d actual=%0d required=%0d", name, step_no, act, req);
      end
   endtask

   task automatic add_stream(bit rst_first, bit ovl, int n, logic [31:0] bits_v, logic [31:0] exp_v);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v          = '0;
         v.rst      = rst_first && (i == 0);
         v.valid    = 1'b1;
         v.bitv     = bits_v[n-1-i];
         v.ovl      = ovl;
         v.exp_seen = exp_v[n-1-i];
         tbl.push_back(v);
      end
   endtask

   // Config load with a 1 bit presented on the same edge (must be dropped)
   task automatic add_cfg(bit rst_first, bit ovl, logic [7:0] pat, logic [3:0] len, bit exp_err);
      vec_t v;
      v         = '0;
      v.rst     = rst_first;
      v.valid   = 1'b1;
      v.bitv    = 1'b1;
      v.load    = 1'b1;
      v.pat     = pat;
      v.len     = len;
      v.ovl     = ovl;
      v.exp_err = exp_err;
      tbl.push_back(v);
   endtask

   task automatic add_gap(bit ovl, bit exp_to);
      vec_t v;
      v        = '0;
      v.bitv   = 1'b1;
      v.ovl    = ovl;
      v.exp_to = exp_to;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      inp_valid = 1'b0;
      cfg_load  = 1'b0;
      cnt_clr   = 1'b0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      model_cnt = 8'd0;
   endtask

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty step %0d actual=0 required=1", step_no);
      end else begin
         e = sb_q.pop_front();
         check1("seq_seen", {31'd0, seq_seen}, {31'd0, e.seen});
         check1("cfg_err", {31'd0, cfg_err}, {31'd0, e.err});
         check1("match_count", {24'd0, match_count}, {24'd0, e.cnt});
`ifdef SEQ_DETECT_TIMEOUT_EN
         check1("timeout", {31'd0, timeout}, {31'd0, e.to});
`endif
      end
   endtask

   task automatic apply(vec_t v);
      exp_t e;
      if (v.rst) do_reset();
      inp_valid   = v.valid;
      inp_bit     = v.bitv;
      cfg_load    = v.load;
      cfg_pattern = v.pat;
      cfg_len     = v.len;
      cnt_clr     = v.clr;
      overlap_en  = v.ovl;
      if (v.clr) begin
         model_cnt = 8'd0;
      end else if (v.exp_seen && (model_cnt != 8'hFF)) begin
         model_cnt = model_cnt + 8'd1;
      end
      e.seen = v.exp_seen;
      e.err  = v.exp_err;
      e.to   = v.exp_to;
      e.cnt  = model_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      check_out();
   endtask

   initial begin
      vec_t v;
      reset       = 1'b1;
      inp_valid   = 1'b0;
      inp_bit     = 1'b0;
      overlap_en  = 1'b1;
      cfg_load    = 1'b0;
      cfg_pattern = 8'd0;
      cfg_len     = 4'd0;
      cnt_clr     = 1'b0;
      model_cnt   = 8'd0;

      // Outputs while reset is held
      @(posedge clk);
      #1;
      check1("rst_seq_seen", {31'd0, seq_seen}, 32'd0);
      check1("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
      check1("rst_match_count", {24'd0, match_count}, 32'd0);
`ifdef SEQ_DETECT_TIMEOUT_EN
      check1("rst_timeout", {31'd0, timeout}, 32'd0);
`endif
      reset = 1'b0;

      // Default 1011, overlapping: pulses after bits 4 and 7
      add_stream(1'b1, 1'b1, 7, 32'b1011011, 32'b0001001);
      // Same stream, non-overlapping: single pulse after bit 4
      add_stream(1'b1, 1'b0, 7, 32'b1011011, 32'b0001000);
      // inp_valid gap freezes a partial match
      add_stream(1'b1, 1'b1, 2, 32'b10, 32'b00);
      add_gap(1'b1, 1'b0);
      add_stream(1'b0, 1'b1, 2, 32'b11, 32'b01);
      // 8-bit pattern 1100_1010; then a stream differing in the last bit
      add_cfg(1'b1, 1'b0, 8'hCA, 4'd8, 1'b0);
      add_stream(1'b0, 1'b0, 8, 32'b11001010, 32'b00000001);
      add_stream(1'b0, 1'b0, 8, 32'b11001011, 32'b00000000);
      // Rejected lengths 0 and 9; reset must have restored the default 1011
      add_cfg(1'b1, 1'b1, 8'hFF, 4'd0, 1'b1);
      add_cfg(1'b0, 1'b1, 8'hFF, 4'd9, 1'b1);
      add_stream(1'b0, 1'b1, 3, 32'b101, 32'b000);
      // Rejected load keeps the partial match but drops its own bit
      add_cfg(1'b0, 1'b1, 8'hFF, 4'd15, 1'b1);
      add_stream(1'b0, 1'b1, 1, 32'b1, 32'b1);
      // Accepted load clears history and drops its bit
      add_stream(1'b0, 1'b1, 3, 32'b101, 32'b000);
      add_cfg(1'b0, 1'b1, 8'h0B, 4'd4, 1'b0);
      add_stream(1'b0, 1'b1, 4, 32'b1011, 32'b0001);
      // len=1: every bit equal to pat[0] matches; upper pattern bits ignored
      add_cfg(1'b0, 1'b0, 8'h01, 4'd1, 1'b0);
      add_stream(1'b0, 1'b0, 4, 32'b1101, 32'b1101);
      add_cfg(1'b0, 1'b1, 8'hFE, 4'd1, 1'b0);
      add_stream(1'b0, 1'b1, 3, 32'b010, 32'b101);
      // Reset mid-stream discards 1,0,1
      add_stream(1'b1, 1'b1, 3, 32'b101, 32'b000);
      add_stream(1'b1, 1'b1, 1, 32'b1, 32'b0);
      add_stream(1'b0, 1'b1, 4, 32'b1011, 32'b0001);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // Counter saturation: len=1 pattern 1, 256 matching bits
      do_reset();
      v = '0; v.valid = 1'b1; v.bitv = 1'b1; v.load = 1'b1; v.pat = 8'h01; v.len = 4'd1; v.ovl = 1'b1;
      apply(v);
      for (int i = 0; i < 256; i++) begin
         v = '0; v.valid = 1'b1; v.bitv = 1'b1; v.ovl = 1'b1; v.exp_seen = 1'b1;
         apply(v);
      end
      check1("cnt_saturated", {24'd0, match_count}, 32'd255);
      // Clear on the same edge as a match wins
      v = '0; v.valid = 1'b1; v.bitv = 1'b1; v.ovl = 1'b1; v.exp_seen = 1'b1; v.clr = 1'b1;
      apply(v);
      v = '0; v.ovl = 1'b1;
      apply(v);

`ifdef SEQ_DETECT_TIMEOUT_EN
      // 1,0,1 then 16 idle edges: timeout on the 16th, next 1 must not match
      do_reset();
      for (int i = 0; i < 3; i++) begin
         v = '0; v.valid = 1'b1; v.bitv = (i != 1); v.ovl = 1'b1;
         apply(v);
      end
      for (int i = 0; i < 16; i++) begin
         v = '0; v.ovl = 1'b1; v.exp_to = (i == 15);
         apply(v);
      end
      v = '0; v.valid = 1'b1; v.bitv = 1'b1; v.ovl = 1'b1;
      apply(v);
`endif

      check1("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
